// File: rtl/fetch_seq_pkg.sv
// Shared types for the mig-u fetch sequencer.
//   fetch_state_t : sequencer FSM states
//   redir_kind_t  : kind of a held redirect (none / branch / exception)
//   pend_entry_t  : pending-redirect entry at the default PC width
package fetch_seq_pkg;

    localparam int unsigned DefAddrWidth    = 18;
    localparam int unsigned DefInsnSizeBits = 2;
    localparam int unsigned DefPcWidth      = DefAddrWidth - DefInsnSizeBits;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StBoot  = 2'd1,
        StRun   = 2'd2,
        StHalt  = 2'd3
    } fetch_state_t;

    // Encoding is ordered by rank so a larger value always wins.
    typedef enum logic [1:0] {
        RedirNone = 2'd0,
        RedirBr   = 2'd1,
        RedirExc  = 2'd2
    } redir_kind_t;

    typedef struct packed {
        redir_kind_t             kind;
        logic [DefPcWidth-1:0]   target;
    } pend_entry_t;

endpackage

// File: rtl/fetch_seq_ctrl_redirect_hold.sv
// One-entry pending-redirect register.
//   capture_i    : sample live exc/br requests into the entry
//   clear_i      : entry consumed, return to empty (wins over capture)
//   exc_*/br_*   : live redirect requests and targets
//   kind_o       : kind of the held entry
//   target_o     : held target word address
// An exception overwrites anything; a branch never overwrites a held exception.
module redirect_hold
    import fetch_seq_pkg::*;
#(
    parameter int unsigned W = DefPcWidth
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         capture_i,
    input  logic         clear_i,
    input  logic         exc_req_i,
    input  logic [W-1:0] exc_vec_i,
    input  logic         br_req_i,
    input  logic [W-1:0] br_target_i,
    output redir_kind_t  kind_o,
    output logic [W-1:0] target_o
);

    redir_kind_t  kind_q, kind_d;
    logic [W-1:0] target_q, target_d;

    always_comb begin
        kind_d   = kind_q;
        target_d = target_q;
        if (clear_i) begin
            kind_d = RedirNone;
        end else if (capture_i) begin
            if (exc_req_i) begin
                kind_d   = RedirExc;
                target_d = exc_vec_i;
            end else if (br_req_i && (kind_q != RedirExc)) begin
                kind_d   = RedirBr;
                target_d = br_target_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kind_q   <= RedirNone;
            target_q <= '0;
        end else begin
            kind_q   <= kind_d;
            target_q <= target_d;
        end
    end

    assign kind_o   = kind_q;
    assign target_o = target_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the fetch PC and drives the imem request port.
//   rst_pc_i               : boot word address, sampled in BOOT
//   exc_req_i / exc_vec_i  : exception redirect (highest priority)
//   br_req_i / br_target_i : branch redirect
//   halt_req_i / resume_i  : stop / restart fetching
//   imem_req_o/imem_addr_o : registered fetch request and word address
//   imem_ready_i           : imem accepts the request this cycle
//   halted_o               : sequencer is in HALT
//   pc_wrap_o              : sticky, sequential PC wrapped past all-ones
module fetch_seq_ctrl
    import fetch_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
    parameter int unsigned INSN_SIZE_BITS = DefInsnSizeBits,
    localparam int unsigned W             = ADDR_WIDTH - INSN_SIZE_BITS
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] rst_pc_i,
    input  logic         exc_req_i,
    input  logic [W-1:0] exc_vec_i,
    input  logic         br_req_i,
    input  logic [W-1:0] br_target_i,
    input  logic         halt_req_i,
    input  logic         resume_i,
    output logic         imem_req_o,
    output logic [W-1:0] imem_addr_o,
    input  logic         imem_ready_i,
    output logic         halted_o,
    output logic         pc_wrap_o
);

    fetch_state_t state_q, state_d;
    logic         req_q, req_d;
    logic [W-1:0] addr_q, addr_d;
    logic         halted_q, halted_d;
    logic         wrap_q, wrap_d;
    logic         halt_pend_q, halt_pend_d;

    redir_kind_t  pend_kind;
    logic [W-1:0] pend_target;
    logic         hold_capture, hold_clear;

    logic         accept;
    logic [W:0]   inc_full;
    logic         redir_taken;
    logic [W-1:0] redir_addr;

    redirect_hold #(
        .W (W)
    ) u_redirect_hold (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .capture_i   (hold_capture),
        .clear_i     (hold_clear),
        .exc_req_i   (exc_req_i),
        .exc_vec_i   (exc_vec_i),
        .br_req_i    (br_req_i),
        .br_target_i (br_target_i),
        .kind_o      (pend_kind),
        .target_o    (pend_target)
    );

    assign accept   = (state_q == StRun) && req_q && imem_ready_i;
    assign inc_full = {1'b0, addr_q} + {{W{1'b0}}, 1'b1};

    // Redirect priority: live exc, held exc, live br, held br.
    // Falls back to the current address when nothing redirects.
    always_comb begin
        redir_taken = 1'b1;
        redir_addr  = addr_q;
        if (exc_req_i) begin
            redir_addr = exc_vec_i;
        end else if (pend_kind == RedirExc) begin
            redir_addr = pend_target;
        end else if (br_req_i) begin
            redir_addr = br_target_i;
        end else if (pend_kind == RedirBr) begin
            redir_addr = pend_target;
        end else begin
            redir_taken = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        halted_d     = halted_q;
        wrap_d       = wrap_q;
        halt_pend_d  = halt_pend_q;
        hold_capture = 1'b0;
        hold_clear   = 1'b0;
        case (state_q)
            StReset: begin
                state_d = StBoot;
            end
            StBoot: begin
                state_d = StRun;
                req_d   = 1'b1;
                addr_d  = rst_pc_i;
            end
            StRun: begin
                if (accept) begin
                    // Any chosen redirect supersedes whatever was held.
                    hold_clear = 1'b1;
                    if (redir_taken) begin
                        addr_d = redir_addr;
                    end else begin
                        addr_d = inc_full[W-1:0];
                        if (inc_full[W]) begin
                            wrap_d = 1'b1;
                        end
                    end
                    if (halt_req_i || halt_pend_q) begin
                        state_d     = StHalt;
                        req_d       = 1'b0;
                        halted_d    = 1'b1;
                        halt_pend_d = 1'b0;
                    end
                end else if (req_q) begin
                    // Stalled: request stays put, redirects/halt are remembered.
                    hold_capture = 1'b1;
                    if (halt_req_i) begin
                        halt_pend_d = 1'b1;
                    end
                end else if (halt_req_i) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            StHalt: begin
                if (resume_i && !halt_req_i) begin
                    state_d    = StRun;
                    req_d      = 1'b1;
                    halted_d   = 1'b0;
                    hold_clear = 1'b1;
                    addr_d     = redir_addr;
                end else begin
                    hold_capture = 1'b1;
                end
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StReset;
            req_q       <= 1'b0;
            addr_q      <= '0;
            halted_q    <= 1'b0;
            wrap_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            halted_q    <= halted_d;
            wrap_q      <= wrap_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign halted_o    = halted_q;
    assign pc_wrap_o   = wrap_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl. Expected fetch addresses are queued
// as stimulus is applied and checked whenever imem accepts a request.
module tb_fetch_seq_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] rst_pc = '0;
    logic         exc_req = 1'b0;
    logic [W-1:0] exc_vec = '0;
    logic         br_req = 1'b0;
    logic [W-1:0] br_target = '0;
    logic         halt_req = 1'b0;
    logic         resume = 1'b0;
    logic         imem_ready = 1'b0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         halted;
    logic         pc_wrap;

    int unsigned  n_tests = 0;
    int unsigned  n_fail = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] sb_exp;

    fetch_seq_ctrl #(
        .ADDR_WIDTH     (18),
        .INSN_SIZE_BITS (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rst_pc_i     (rst_pc),
        .exc_req_i    (exc_req),
        .exc_vec_i    (exc_vec),
        .br_req_i     (br_req),
        .br_target_i  (br_target),
        .halt_req_i   (halt_req),
        .resume_i     (resume),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ready_i (imem_ready),
        .halted_o     (halted),
        .pc_wrap_o    (pc_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a);
        sb_q.push_back(a);
    endtask

    // Every accepted request must match the next queued address.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra", 32'(sb_q.size()), 32'd1);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_addr", 32'(imem_addr), 32'(sb_exp));
            end
        end
    end

    initial begin
        imem_ready = 1'b1;
        rst_pc     = 16'h0100;
        #1 rst = 1'b1;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_wrap", 32'(pc_wrap), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Boot
        push(16'h0100); push(16'h0101); push(16'h0102);
        step();                                     // E0: BOOT
        check("boot_req_e0", 32'(imem_req), 32'd0);
        step();                                     // E1: RUN
        check("boot_req_e1", 32'(imem_req), 32'd1);
        check("boot_addr", 32'(imem_addr), 32'h0100);
        check("boot_halted", 32'(halted), 32'd0);
        step();                                     // 0x101
        step();                                     // 0x102
        br_req = 1'b1; br_target = 16'h0200; push(16'h0200);
        step();                                     // 0x200

        // Same-cycle exc and br: exc wins, br dropped
        br_target = 16'h0300;
        exc_req = 1'b1; exc_vec = 16'h0010;
        push(16'h0010); push(16'h0011);
        step();                                     // 0x010
        br_req = 1'b0; exc_req = 1'b0;
        step();                                     // 0x011

        // Stalled branch redirect
        br_req = 1'b1; br_target = 16'h0400;
        step();                                     // 0x400
        br_req = 1'b0; imem_ready = 1'b0;
        step();
        check("stall_hold0", 32'(imem_addr), 32'h0400);
        br_req = 1'b1; br_target = 16'h0500;
        step();
        br_req = 1'b0;
        check("stall_hold1", 32'(imem_addr), 32'h0400);
        check("stall_req", 32'(imem_req), 32'd1);
        step();
        imem_ready = 1'b1; push(16'h0400); push(16'h0500);
        step();                                     // 0x500
        step();                                     // 0x501

        // Pending br overwritten by a later exc during a stall
        imem_ready = 1'b0;
        step();
        br_req = 1'b1; br_target = 16'h0600;
        step();
        br_req = 1'b0; exc_req = 1'b1; exc_vec = 16'h0020;
        step();
        exc_req = 1'b0; imem_ready = 1'b1;
        push(16'h0501); push(16'h0020);
        step();                                     // 0x020

        // Sequential wrap
        br_req = 1'b1; br_target = 16'hFFFE; push(16'hFFFE);
        step();                                     // 0xFFFE
        br_req = 1'b0; push(16'hFFFF); push(16'h0000);
        check("wrap_pre", 32'(pc_wrap), 32'd0);
        step();                                     // 0xFFFF
        check("wrap_pre2", 32'(pc_wrap), 32'd0);
        step();                                     // 0x0000
        check("wrap_set", 32'(pc_wrap), 32'd1);
        check("wrap_addr", 32'(imem_addr), 32'h0000);
        br_req = 1'b1; br_target = 16'h0700; push(16'h0700);
        step();                                     // 0x700
        br_req = 1'b0;
        check("wrap_sticky", 32'(pc_wrap), 32'd1);

        // Halt at the accept of 0x700, then resume at the retained 0x701
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_req_lo", 32'(imem_req), 32'd0);
        step();
        check("halt_stays", 32'(halted), 32'd1);
        resume = 1'b1; push(16'h0701);
        step();
        resume = 1'b0;
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_addr", 32'(imem_addr), 32'h0701);
        step();                                     // 0x702 presented

        // Asynchronous reset mid-RUN, checked before the next clock edge
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_wrap", 32'(pc_wrap), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
